// File: rtl/tiny16_pkg.sv
// ---------------------------------------------------------------
// tiny16_pkg : shared FSM encoding and MMIO addresses for bus_mem
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package tiny16_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } state_e;

    localparam logic [15:0] IO_OUT_ADDR = 16'hFFFF;
    localparam logic [15:0] IO_IN_ADDR  = 16'hFFFE;

    // True when addr falls inside a RAM of 2^aw words.
    function automatic logic addr_in_range(input logic [15:0] addr, input int aw);
        return (aw >= 16) || ((addr >> aw) == 16'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_mem_ram.sv
// ---------------------------------------------------------------
// bus_mem_ram : synchronous single-port 16-bit RAM, registered read
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module bus_mem_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [15:0]       wdata_i,
    output logic [15:0]       rdata_o
);

    logic [15:0] mem_q [2**ADDR_W];
    logic [15:0] rdata_q;

    // Contents are deliberately not reset; rdata holds between reads.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/bus_mem.sv
// ---------------------------------------------------------------
// bus_mem : strobe-driven bus responder with wait-stated RAM reads.
// Optional MMIO port enabled by defining BUS_MEM_IO_EN.   Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module bus_mem #(
    parameter int ADDR_W = 12,
    parameter int WAIT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_addr_en,
    input  logic        mem_in_en,
    input  logic        mem_out_en,
    input  logic [15:0] bus_in,
    output logic [15:0] bus_out,
    output logic        bus_out_en,
    output logic        ready,
    output logic        err,
    output logic [15:0] io_out,
    output logic        io_valid,
    input  logic [15:0] io_in
);

    import tiny16_pkg::*;

    state_e      state_q;
    logic [15:0] addr_q;
    logic [2:0]  cnt_q;
    logic [15:0] bus_out_q;
    logic        bus_out_en_q;
    logic        err_q;
    logic [15:0] io_out_q;
    logic        io_valid_q;
    logic        rd_ram_q;
    logic [15:0] rd_alt_q;

    logic [15:0] io_sample;
    logic [15:0] ram_rdata;

`ifdef BUS_MEM_IO_EN
    localparam bit IO_EN = 1'b1;
    assign io_sample = io_in;
`else
    localparam bit IO_EN = 1'b0;
    logic unused_io;
    assign io_sample = 16'h0000;
    assign unused_io = ^io_in;
`endif

    logic is_idle, addr_ok, io_wr_hit, io_rd_hit, multi_strobe, any_strobe;
    logic ram_we, ram_re;

    assign is_idle      = (state_q == IDLE);
    assign addr_ok      = addr_in_range(addr_q, ADDR_W);
    assign io_wr_hit    = IO_EN && (addr_q == IO_OUT_ADDR);
    assign io_rd_hit    = IO_EN && (addr_q == IO_IN_ADDR);
    assign any_strobe   = mem_addr_en | mem_in_en | mem_out_en;
    assign multi_strobe = (mem_addr_en & mem_in_en) | (mem_addr_en & mem_out_en)
                        | (mem_in_en & mem_out_en);

    // RAM strobes follow the addr > write > read priority.
    assign ram_we = is_idle && !mem_addr_en && mem_in_en && !io_wr_hit && addr_ok;
    assign ram_re = is_idle && !mem_addr_en && !mem_in_en && mem_out_en
                    && !io_rd_hit && addr_ok;

    bus_mem_ram #(
        .ADDR_W (ADDR_W)
    ) ram (
        .clk     (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (addr_q[ADDR_W-1:0]),
        .wdata_i (bus_in),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            addr_q       <= 16'h0000;
            cnt_q        <= 3'd0;
            bus_out_q    <= 16'h0000;
            bus_out_en_q <= 1'b0;
            err_q        <= 1'b0;
            io_out_q     <= 16'h0000;
            io_valid_q   <= 1'b0;
            rd_ram_q     <= 1'b0;
            rd_alt_q     <= 16'h0000;
        end else begin
            bus_out_q    <= 16'h0000;
            bus_out_en_q <= 1'b0;
            io_valid_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (multi_strobe) begin
                        err_q <= 1'b1;
                    end
                    if (mem_addr_en) begin
                        addr_q <= bus_in;
                    end else if (mem_in_en) begin
                        if (io_wr_hit) begin
                            io_out_q   <= bus_in;
                            io_valid_q <= 1'b1;
                        end else if (!addr_ok) begin
                            err_q <= 1'b1;
                        end
                    end else if (mem_out_en) begin
                        cnt_q   <= 3'(WAIT);
                        state_q <= READ;
                        if (io_rd_hit) begin
                            rd_ram_q <= 1'b0;
                            rd_alt_q <= io_sample;
                        end else if (addr_ok) begin
                            rd_ram_q <= 1'b1;
                        end else begin
                            rd_ram_q <= 1'b0;
                            rd_alt_q <= 16'h0000;
                            err_q    <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (any_strobe) begin
                        err_q <= 1'b1;
                    end
                    if (cnt_q == 3'd0) begin
                        bus_out_q    <= rd_ram_q ? ram_rdata : rd_alt_q;
                        bus_out_en_q <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready      = is_idle;
    assign bus_out    = bus_out_q;
    assign bus_out_en = bus_out_en_q;
    assign err        = err_q;
    assign io_out     = io_out_q;
    assign io_valid   = io_valid_q;

endmodule

`default_nettype wire

// File: doc/bus_mem.md
BUS_MEM -- requirements
Module: bus_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning RAM word-address width (depth 2^ADDR_W x 16).
REQ-002 SHALL have parameter WAIT, default 1, range 0..7, meaning extra read wait cycles.
REQ-003 SHALL have port clk, input, 1, meaning the single clock (all logic on its rising edge).
REQ-004 SHALL have port rst, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have port mem_addr_en, input, 1, meaning latch address from bus_in.
REQ-006 SHALL have port mem_in_en, input, 1, meaning write bus_in at the latched address.
REQ-007 SHALL have port mem_out_en, input, 1, meaning read the latched address.
REQ-008 SHALL have port bus_in, input, 16, meaning the address/write-data bus from the controller.
REQ-009 SHALL have port bus_out, output, 16, meaning read data (0 when bus_out_en=0; no tristate).
REQ-010 SHALL have port bus_out_en, output, 1, meaning bus_out valid for exactly one cycle.
REQ-011 SHALL have port ready, output, 1, meaning the responder accepts strobes this cycle.
REQ-012 SHALL have port err, output, 1, meaning a sticky protocol/range error flag.
REQ-013 SHALL have ports io_out (output, 16), io_valid (output, 1) and io_in (input, 16), meaning memory-mapped I/O (see Configuration).

Function
REQ-014 SHALL implement the FSM states IDLE and READ; ready=1 only in IDLE.
REQ-015 SHALL, in IDLE on mem_addr_en, register addr_q<=bus_in (16 bits) and remain in IDLE.
REQ-016 SHALL, in IDLE on mem_in_en with an in-range addr_q, write bus_in to RAM on that edge (single cycle).
REQ-017 SHALL, in IDLE on mem_out_en, load wait counter=WAIT and enter READ.
REQ-018 SHALL, in READ, decrement the counter each cycle; when it is 0, drive bus_out=data and bus_out_en=1 and return to IDLE on that same edge; read latency from strobe to bus_out_en=WAIT+2 cycles.
REQ-019 SHALL resolve simultaneous strobes with priority addr > write > read, execute only the highest, drop the rest and set err.
REQ-020 SHALL ignore any strobe received while in READ and set err.
REQ-021 SHALL treat addr_q >= 2^ADDR_W (non-MMIO) as out of range: writes dropped, reads return 16'h0000 with normal latency, err set.
REQ-022 SHALL keep err at 1 until reset.
REQ-023 SHALL reflect a write followed immediately by a read of the same address with the new data.

Reset
REQ-024 SHALL, while rst=0, force state=IDLE, addr_q=0, counter=0, bus_out=0, bus_out_en=0, err=0, io_out=0, io_valid=0; ready=1 from the first edge after release.
REQ-025 SHALL abort an in-progress read on reset; bus_out_en SHALL NOT be asserted for it.
REQ-026 SHALL NOT reset RAM contents.

Configuration
REQ-027 SHALL, with macro BUS_MEM_IO_EN defined, map write to 16'hFFFF as io_out<=bus_in with io_valid=1 for one cycle (RAM untouched), and map read of 16'hFFFE as returning io_in sampled at the mem_out_en edge.
REQ-028 SHALL, without BUS_MEM_IO_EN, tie io_out=0 and io_valid=0, ignore io_in, and treat 16'hFFFE and 16'hFFFF as ordinary out-of-range addresses.

Structure
REQ-029 SHALL place the FSM state encoding, IO_OUT_ADDR=16'hFFFF and IO_IN_ADDR=16'hFFFE in shared package tiny16_pkg.
REQ-030 SHALL instantiate one sub-module, ram, as a synchronous single-port 16-bit RAM with a registered read.

Verification
REQ-031 SHALL cover: addr_en bus_in=0x0010, in_en bus_in=0xBEEF, addr_en 0x0010, out_en with WAIT=1 -> bus_out_en at 3rd edge after out_en, bus_out=0xBEEF, err=0.
REQ-032 SHALL cover: WAIT=0 read of 0x0010 -> bus_out_en 2 cycles after the strobe; WAIT=3 -> 5 cycles; ready=0 throughout.
REQ-033 SHALL cover: mem_addr_en and mem_out_en asserted together with bus_in=0x0020 -> addr_q=0x0020, no read issued, err=1.
REQ-034 SHALL cover: addr 0x1000 (ADDR_W=12), write 0x1234 then read -> RAM unchanged, bus_out=0x0000, err=1.
REQ-035 SHALL cover: BUS_MEM_IO_EN defined, write 0x00AA to 0xFFFF -> io_out=0x00AA with a one-cycle io_valid; read 0xFFFE with io_in=0x5555 -> bus_out=0x5555.
REQ-036 SHALL cover: rst=0 pulsed in READ -> bus_out_en stays 0, ready=1 after release, subsequent read of 0x0010 returns 0xBEEF.
